rc4_stream_ctrl: RTL

Sequencer and two-port arbiter for the RC4 keystream engine. It loads a 32-bit session key, starts the engine's key schedule, and waits for completion with a timeout. It then shares the single keystream between two requesters: four keystream bytes are gathered per 32-bit word and XORed with the granted requester's plaintext. The block sits between the host/requester side and the RC4 engine; the engine's internal state is not visible here.

---
 rtl/rc4_stream_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl
// Sequencer and two-port arbiter for an RC4 keystream engine. It loads a
// session key, runs the engine key schedule with a timeout, then serves two
// requesters round-robin. Each granted 32-bit word is XORed with four
// keystream bytes, LSB first, and presented downstream.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   key_load, key_in     key latch / schedule (re)start, 32-bit session key
//   req_valid[1:0]       per-requester word valid
//   req_data0/1          requester plaintext words
//   req_ready[1:0]       one-hot accept strobe (word consumed this cycle)
//   out_valid/ready      ciphertext handshake
//   out_data, out_id     ciphertext word and source requester index
//   busy, err            activity flag, sticky timeout flag
//   eng_key, eng_init    engine key and schedule start pulse
//   eng_init_done        engine schedule-complete pulse
//   eng_ks_req           one-cycle keystream byte request
//   eng_ks_valid/byte    keystream byte return
module rc4_stream_ctrl #(
  parameter int INIT_TIMEOUT = 1024,
  parameter int KS_TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_load,
  input  logic [31:0] key_in,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_data0,
  input  logic [31:0] req_data1,
  output logic [1:0]  req_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_id,
  output logic        busy,
  output logic        err,
  output logic [31:0] eng_key,
  output logic        eng_init,
  input  logic        eng_init_done,
  output logic        eng_ks_req,
  input  logic        eng_ks_valid,
  input  logic [7:0]  eng_ks_byte
);

  localparam int IW = $clog2(INIT_TIMEOUT + 1);
  localparam int KW = $clog2(KS_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_TIMEOUT - 1);
  localparam logic [KW-1:0] KS_LAST   = KW'(KS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_READY, S_GATHER, S_OUT, S_ERROR
  } state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   init_cnt;
  logic [KW-1:0]   ks_tmr;
  logic [1:0]      idx;
  logic            pend;     // one keystream request outstanding
  logic            rr;       // index of the last granted requester
  logic [1:0]      gnt;
  logic            ks_hit;

  // Only a byte answering our own outstanding request is used.
  assign ks_hit = pend & eng_ks_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; key_load overrides every state.
  always_comb begin
    state_nx = state;
    if (key_load) begin
      state_nx = S_INIT;
    end else begin
      case (state)
        S_IDLE:   state_nx = S_IDLE;
        S_INIT:   if (eng_init_done)          state_nx = S_READY;
                  else if (init_cnt == INIT_LAST) state_nx = S_ERROR;
        S_READY:  if (|gnt)                   state_nx = S_GATHER;
        S_GATHER: if (ks_hit && idx == 2'd3)  state_nx = S_OUT;
                  else if (pend && !eng_ks_valid && ks_tmr == KS_LAST)
                                              state_nx = S_ERROR;
        S_OUT:    if (out_ready)              state_nx = S_READY;
        S_ERROR:  state_nx = S_ERROR;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  // Output logic. A same-cycle key_load suppresses grants and requests so an
  // aborted word is never acknowledged and no stray byte is pulled.
  always_comb begin
    gnt = 2'b00;
    if (state == S_READY && !key_load) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    req_ready  = gnt;
    eng_ks_req = (state == S_GATHER) && !pend && !key_load;
    out_valid  = (state == S_OUT);
    busy       = (state == S_INIT) || (state == S_GATHER) ||
                 (state == S_OUT)  || (state == S_ERROR);
  end

  // Datapath and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_key  <= '0;
      eng_init <= 1'b0;
      err      <= 1'b0;
      init_cnt <= '0;
      ks_tmr   <= '0;
      idx      <= '0;
      pend     <= 1'b0;
      rr       <= 1'b0;
      out_data <= '0;
      out_id   <= 1'b0;
    end else begin
      eng_init <= key_load;
      if (key_load) begin
        eng_key  <= key_in;
        err      <= 1'b0;
        init_cnt <= '0;
        idx      <= '0;
        pend     <= 1'b0;
      end else begin
        if (state_nx == S_ERROR && state != S_ERROR) err <= 1'b1;
        if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
        if (|gnt) begin
          out_data <= gnt[1] ? req_data1 : req_data0;
          out_id   <= gnt[1];
          rr       <= gnt[1];
          idx      <= '0;
          pend     <= 1'b0;
        end
        if (eng_ks_req) begin
          pend   <= 1'b1;
          ks_tmr <= '0;
        end else if (ks_hit) begin
          out_data[{idx, 3'b000} +: 8] <= out_data[{idx, 3'b000} +: 8] ^ eng_ks_byte;
          idx  <= idx + 1'b1;
          pend <= 1'b0;
        end else if (pend) begin
          ks_tmr <= ks_tmr + 1'b1;
          if (ks_tmr == KS_LAST) pend <= 1'b0;
        end
      end
    end
  end

endmodule
